// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter.
package mem_arb_pkg;

    localparam int DefNumMasters    = 4;
    localparam int DefAddrWidth     = 32;
    localparam int DefDataWidth     = 32;
    localparam int DefTimeoutCycles = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_grant.sv
// Round-robin search: first set request at or above ptr, wrapping around.
module rr_grant
    import mem_arb_pkg::*;
#(
    parameter int NumReq = DefNumMasters,
    parameter int IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic              found,
    output logic [IdxW-1:0]   winner
);

    logic [31:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NumReq; k++) begin
            idx = 32'(ptr) + 32'(k);
            if (idx >= 32'(NumReq)) begin
                idx = idx - 32'(NumReq);
            end
            if (!found && req[IdxW'(idx)]) begin
                found  = 1'b1;
                winner = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving N masters single-outstanding access to one slave port.
//   state   | meaning
//   IDLE    | no owner; pick next requester from ptr
//   REQ     | owner's request presented to slave until accepted
//   RESP    | waiting for slave response or timeout
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NumMasters    = DefNumMasters,
    parameter int AddrWidth     = DefAddrWidth,
    parameter int DataWidth     = DefDataWidth,
    parameter int TimeoutCycles = DefTimeoutCycles
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NumMasters-1:0]                m_req_valid_i,
    output logic [NumMasters-1:0]                m_req_ready_o,
    input  logic [NumMasters*AddrWidth-1:0]      m_addr_i,
    input  logic [NumMasters*DataWidth-1:0]      m_wdata_i,
    input  logic [NumMasters*(DataWidth/8)-1:0]  m_be_i,
    input  logic [NumMasters-1:0]                m_we_i,
    output logic [NumMasters-1:0]                m_rsp_valid_o,
    output logic [DataWidth-1:0]                 m_rsp_rdata_o,
    output logic                                 m_rsp_err_o,
    output logic                                 s_req_valid_o,
    input  logic                                 s_req_ready_i,
    output logic [AddrWidth-1:0]                 s_addr_o,
    output logic [DataWidth-1:0]                 s_wdata_o,
    output logic [(DataWidth/8)-1:0]             s_be_o,
    output logic                                 s_we_o,
    input  logic                                 s_rsp_valid_i,
    input  logic [DataWidth-1:0]                 s_rsp_rdata_i,
    input  logic                                 s_rsp_err_i,
    output logic [idx_width(NumMasters)-1:0]     grant_idx_o,
    output logic                                 busy_o
);

    localparam int BeW  = DataWidth / 8;
    localparam int IdxW = idx_width(NumMasters);
    localparam int TmrW = idx_width(TimeoutCycles);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumMasters - 1);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);

    arb_state_e      state, state_nxt;
    logic [IdxW-1:0] owner, ptr, winner, ptr_inc;
    logic [TmrW-1:0] timer;
    logic            any_req, complete;

    logic [AddrWidth-1:0] addr_arr  [NumMasters];
    logic [DataWidth-1:0] wdata_arr [NumMasters];
    logic [BeW-1:0]       be_arr    [NumMasters];

    for (genvar g = 0; g < NumMasters; g++) begin : g_slice
        assign addr_arr[g]  = m_addr_i[g*AddrWidth +: AddrWidth];
        assign wdata_arr[g] = m_wdata_i[g*DataWidth +: DataWidth];
        assign be_arr[g]    = m_be_i[g*BeW +: BeW];

        // Masters must hold request and payload until they see ready.
        hold_until_ready : assert property (@(posedge clk) disable iff (!rst_n)
            (m_req_valid_i[g] && !m_req_ready_o[g]) |=>
            (m_req_valid_i[g] && $stable(addr_arr[g]) && $stable(wdata_arr[g])
             && $stable(be_arr[g]) && $stable(m_we_i[g])));
    end

    rr_grant #(
        .NumReq (NumMasters),
        .IdxW   (IdxW)
    ) u_rr_grant (
        .req    (m_req_valid_i),
        .ptr    (ptr),
        .found  (any_req),
        .winner (winner)
    );

    assign ptr_inc     = (owner == LastIdx) ? '0 : owner + IdxW'(1);
    assign busy_o      = rst_n && (state != ST_IDLE);
    assign grant_idx_o = rst_n ? owner : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= '0;
            ptr   <= '0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                owner <= winner;
            end
            if (state == ST_REQ && s_req_ready_i) begin
                timer <= '0;
            end else if (state == ST_RESP && !complete) begin
                timer <= timer + TmrW'(1);
            end
            if (complete) begin
                ptr <= ptr_inc;
            end
        end
    end

    // Outputs are forced quiet while reset is asserted so an abandoned transaction never strobes.
    always_comb begin
        state_nxt     = state;
        complete      = 1'b0;
        s_req_valid_o = 1'b0;
        s_addr_o      = '0;
        s_wdata_o     = '0;
        s_be_o        = '0;
        s_we_o        = 1'b0;
        m_req_ready_o = '0;
        m_rsp_valid_o = '0;
        m_rsp_rdata_o = '0;
        m_rsp_err_o   = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    s_req_valid_o        = 1'b1;
                    s_addr_o             = addr_arr[owner];
                    s_wdata_o            = wdata_arr[owner];
                    s_be_o               = be_arr[owner];
                    s_we_o               = m_we_i[owner];
                    m_req_ready_o[owner] = s_req_ready_i;
                    if (s_req_ready_i) begin
                        state_nxt = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (s_rsp_valid_i) begin
                        m_rsp_valid_o[owner] = 1'b1;
                        m_rsp_rdata_o        = s_rsp_rdata_i;
                        m_rsp_err_o          = s_rsp_err_i;
                        complete             = 1'b1;
                        state_nxt            = ST_IDLE;
                    end else if (timer == TmrLast) begin
                        m_rsp_valid_o[owner] = 1'b1;
                        m_rsp_err_o          = 1'b1;
                        complete             = 1'b1;
                        state_nxt            = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int T  = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      m_req_valid_i = '0;
    logic [N-1:0]      m_req_ready_o;
    logic [N*AW-1:0]   m_addr_i = '0;
    logic [N*DW-1:0]   m_wdata_i = '0;
    logic [N*BW-1:0]   m_be_i = '0;
    logic [N-1:0]      m_we_i = '0;
    logic [N-1:0]      m_rsp_valid_o;
    logic [DW-1:0]     m_rsp_rdata_o;
    logic              m_rsp_err_o;
    logic              s_req_valid_o;
    logic              s_req_ready_i = 1'b0;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_wdata_o;
    logic [BW-1:0]     s_be_o;
    logic              s_we_o;
    logic              s_rsp_valid_i = 1'b0;
    logic [DW-1:0]     s_rsp_rdata_i = '0;
    logic              s_rsp_err_i = 1'b0;
    logic [IW-1:0]     grant_idx_o;
    logic              busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NumMasters(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid_i(m_req_valid_i), .m_req_ready_o(m_req_ready_o),
        .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_be_i(m_be_i), .m_we_i(m_we_i),
        .m_rsp_valid_o(m_rsp_valid_o), .m_rsp_rdata_o(m_rsp_rdata_o), .m_rsp_err_o(m_rsp_err_o),
        .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_be_o(s_be_o), .s_we_o(s_we_o),
        .s_rsp_valid_i(s_rsp_valid_i), .s_rsp_rdata_i(s_rsp_rdata_i), .s_rsp_err_i(s_rsp_err_i),
        .grant_idx_o(grant_idx_o), .busy_o(busy_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int from);
        for (int k = 0; k < N; k++) begin
            if (req[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    // Model: one transaction record (owner, accepted yet, cycles waited) plus the rotation pointer.
    int         md_ptr = 0, md_owner = 0, md_age = 0;
    bit         md_active = 0, md_sent = 0;
    logic [N-1:0] hs_q = '0;
    int         grant_q[$];
    int         waits[N];

    always @(negedge clk) begin : model_check
        logic [N-1:0]  e_ready, e_rsp;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_rdata;
        logic [BW-1:0] e_be;
        logic          e_sv, e_we, e_err, e_busy;
        logic [IW-1:0] e_grant;
        int            w;
        e_ready = '0; e_rsp = '0; e_addr = '0; e_wdata = '0; e_rdata = '0; e_be = '0;
        e_sv = 0; e_we = 0; e_err = 0; e_busy = 0; e_grant = '0;
        if (rst_n) begin
            e_grant = IW'(md_owner);
            e_busy  = md_active;
            if (md_active && !md_sent) begin
                e_sv    = 1;
                e_addr  = m_addr_i[md_owner*AW +: AW];
                e_wdata = m_wdata_i[md_owner*DW +: DW];
                e_be    = m_be_i[md_owner*BW +: BW];
                e_we    = m_we_i[md_owner];
                e_ready[md_owner] = s_req_ready_i;
            end else if (md_active) begin
                if (s_rsp_valid_i) begin
                    e_rsp[md_owner] = 1;
                    e_rdata = s_rsp_rdata_i;
                    e_err   = s_rsp_err_i;
                end else if (md_age == T - 1) begin
                    e_rsp[md_owner] = 1;
                    e_err = 1;
                end
            end
        end
        chk("s_req_valid", s_req_valid_o, e_sv);
        chk("s_addr", s_addr_o, e_addr);
        chk("s_wdata", s_wdata_o, e_wdata);
        chk("s_be", s_be_o, e_be);
        chk("s_we", s_we_o, e_we);
        chk("m_req_ready", m_req_ready_o, e_ready);
        chk("m_rsp_valid", m_rsp_valid_o, e_rsp);
        chk("m_rsp_rdata", m_rsp_rdata_o, e_rdata);
        chk("m_rsp_err", m_rsp_err_o, e_err);
        chk("busy", busy_o, e_busy);
        chk("grant_idx", grant_idx_o, e_grant);

        hs_q = rst_n ? (m_req_ready_o & m_req_valid_i) : '0;
        for (int i = 0; i < N; i++) begin
            if (hs_q[i]) begin
                grant_q.push_back(i);
                chk("fair_wait", (waits[i] <= N - 1) ? 0 : waits[i], 0);
                waits[i] = 0;
            end
        end
        if (m_rsp_valid_o != '0) begin
            for (int i = 0; i < N; i++) begin
                if (!m_rsp_valid_o[i] && m_req_valid_i[i]) waits[i]++;
            end
        end

        if (!rst_n) begin
            md_active = 0; md_sent = 0; md_ptr = 0; md_owner = 0; md_age = 0;
            for (int i = 0; i < N; i++) waits[i] = 0;
        end else if (!md_active) begin
            w = rr_pick(m_req_valid_i, md_ptr);
            if (w >= 0) begin
                md_owner = w; md_active = 1; md_sent = 0;
            end
        end else if (!md_sent) begin
            if (s_req_ready_i) begin
                md_sent = 1; md_age = 0;
            end
        end else if (s_rsp_valid_i || md_age == T - 1) begin
            md_active = 0;
            md_ptr = (md_owner + 1) % N;
        end else begin
            md_age++;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        m_req_valid_i = '0; m_addr_i = '0; m_wdata_i = '0; m_be_i = '0; m_we_i = '0;
        s_req_ready_i = 0; s_rsp_valid_i = 0; s_rsp_rdata_i = '0; s_rsp_err_i = 0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 0;
        clear_inputs();
        settle();
        chk("rst_busy", busy_o, 0);
        chk("rst_s_req_valid", s_req_valid_o, 0);
        chk("rst_grant", grant_idx_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic set_master(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [BW-1:0] be, input logic we);
        m_req_valid_i[i] = 1;
        m_addr_i[i*AW +: AW] = a;
        m_wdata_i[i*DW +: DW] = d;
        m_be_i[i*BW +: BW] = be;
        m_we_i[i] = we;
    endtask

    task automatic rand_cycles(input int n, input int p_req, input int p_rdy, input int p_rsp);
        for (int c = 0; c < n; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (hs_q[i] || !m_req_valid_i[i]) begin
                    if ($urandom_range(99) < p_req)
                        set_master(i, $urandom, $urandom, BW'($urandom), 1'($urandom));
                    else
                        m_req_valid_i[i] = 0;
                end
            end
            s_req_ready_i = ($urandom_range(99) < p_rdy);
            s_rsp_valid_i = ($urandom_range(99) < p_rsp);
            s_rsp_rdata_i = $urandom;
            s_rsp_err_i   = 1'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Single read from master 2, response three cycles after acceptance.
        set_master(2, 32'h0000_2000, 32'h0, 4'hF, 1'b0);
        s_req_ready_i = 1;
        settle();
        chk("a_idle_busy", busy_o, 0);
        step(); settle();
        chk("a_req_valid", s_req_valid_o, 1);
        chk("a_req_ready", m_req_ready_o, 4'b0100);
        chk("a_addr", s_addr_o, 32'h0000_2000);
        chk("a_grant", grant_idx_o, 2);
        step();
        m_req_valid_i[2] = 0; s_req_ready_i = 0;
        settle();
        chk("a_rsp_quiet", m_rsp_valid_o, 0);
        step(); step();
        s_rsp_valid_i = 1; s_rsp_rdata_i = 32'hDEAD_BEEF; s_rsp_err_i = 0;
        settle();
        chk("a_rsp_valid", m_rsp_valid_o, 4'b0100);
        chk("a_rsp_rdata", m_rsp_rdata_o, 32'hDEAD_BEEF);
        chk("a_rsp_err", m_rsp_err_o, 0);
        step();
        s_rsp_valid_i = 0;
        settle();
        chk("a_done_busy", busy_o, 0);

        // Reset during RESP; ptr is 3 here so master 0 winning proves ptr was cleared.
        set_master(1, 32'h0000_1000, 32'h0, 4'hF, 1'b0);
        s_req_ready_i = 1;
        step(); settle();
        chk("e_grant1", grant_idx_o, 1);
        step();
        m_req_valid_i[1] = 0; s_req_ready_i = 0;
        rst_n = 0; s_rsp_valid_i = 1; s_rsp_rdata_i = 32'h55;
        settle();
        chk("e_rst_rsp", m_rsp_valid_o, 0);
        chk("e_rst_busy", busy_o, 0);
        step();
        rst_n = 1; s_rsp_valid_i = 0;
        set_master(0, 32'hC0C0_0000, 32'h1, 4'h1, 1'b0);
        set_master(1, 32'hC0C0_0001, 32'h2, 4'h2, 1'b0);
        set_master(3, 32'hC0C0_0003, 32'h3, 4'h4, 1'b0);
        settle();
        chk("e_idle_busy", busy_o, 0);
        chk("e_idle_rsp", m_rsp_valid_o, 0);
        step(); settle();
        chk("e_grant0", grant_idx_o, 0);
        chk("e_addr0", s_addr_o, 32'hC0C0_0000);
        rand_cycles(20, 0, 100, 100);

        // Silent slave: error strobe on the 8th RESP cycle, late response ignored.
        do_reset();
        set_master(1, 32'h0000_0111, 32'h0, 4'hF, 1'b0);
        s_req_ready_i = 1;
        step(); settle();
        chk("c_req_ready", m_req_ready_o, 4'b0010);
        step();
        m_req_valid_i[1] = 0; s_req_ready_i = 0;
        set_master(0, 32'h0000_0AAA, 32'h0, 4'hF, 1'b0);
        set_master(2, 32'h0000_0CCC, 32'h0, 4'hF, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            settle();
            chk("c_no_strobe", m_rsp_valid_o, 0);
            step();
        end
        settle();
        chk("c_to_valid", m_rsp_valid_o, 4'b0010);
        chk("c_to_err", m_rsp_err_o, 1);
        chk("c_to_rdata", m_rsp_rdata_o, 0);
        step(); settle();
        chk("c_idle_busy", busy_o, 0);
        step();
        s_rsp_valid_i = 1; s_rsp_rdata_i = 32'h7777_7777;
        settle();
        chk("c_ptr_adv", grant_idx_o, 2);
        chk("c_late_drop", m_rsp_valid_o, 0);
        s_rsp_valid_i = 0;
        rand_cycles(30, 0, 100, 100);

        // Slave stalls for 5 REQ cycles; payload must stay put.
        do_reset();
        set_master(3, 32'hA5A5_0003, 32'h1357_9BDF, 4'b1010, 1'b1);
        s_req_ready_i = 0;
        for (int k = 0; k < 5; k++) begin
            step(); settle();
            chk("d_sv", s_req_valid_o, 1);
            chk("d_addr", s_addr_o, 32'hA5A5_0003);
            chk("d_wdata", s_wdata_o, 32'h1357_9BDF);
            chk("d_be", s_be_o, 4'b1010);
            chk("d_we", s_we_o, 1);
            chk("d_no_ready", m_req_ready_o, 0);
        end
        step();
        s_req_ready_i = 1;
        settle();
        chk("d_ready", m_req_ready_o, 4'b1000);
        step();
        m_req_valid_i[3] = 0; m_we_i[3] = 0; s_req_ready_i = 0;
        s_rsp_valid_i = 1; s_rsp_rdata_i = 32'h0000_1234; s_rsp_err_i = 0;
        settle();
        chk("d_rsp", m_rsp_valid_o, 4'b1000);
        chk("d_rdata", m_rsp_rdata_o, 32'h0000_1234);
        step();
        s_rsp_valid_i = 0;

        // All masters requesting continuously: order 0,1,2,3,0 including the 3 -> 0 wrap.
        do_reset();
        grant_q.delete();
        for (int c = 0; c < 40 && grant_q.size() < 5; c++) rand_cycles(1, 100, 100, 100);
        chk("b_grant_count", (grant_q.size() >= 5) ? 5 : grant_q.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("b_grant_order", (k < grant_q.size()) ? grant_q[k] : 99, k % N);
        end

        for (int b = 0; b < 10; b++) begin
            case (b % 5)
                0: rand_cycles(300, 50, 50, 30);
                1: rand_cycles(300, 80, 20, 10);
                2: rand_cycles(300, 100, 100, 100);
                3: rand_cycles(300, 30, 70, 3);
                default: rand_cycles(300, 100, 60, 50);
            endcase
            if (b % 3 == 2) do_reset();
        end
        rand_cycles(40, 0, 100, 100);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 NumMasters, default 4, number of requesting masters (>=2) SHALL be supported.
REQ-002 AddrWidth, default 32, request address width SHALL be supported.
REQ-003 DataWidth, default 32, data width, multiple of 8, SHALL be supported.
REQ-004 TimeoutCycles, default 255, RESP-state cycles before error completion, >=1, SHALL be supported.
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-007 m_req_valid_i  in  NumMasters  per-master request valid.
REQ-008 m_req_ready_o  out  NumMasters  per-master request accepted.
REQ-009 m_addr_i  in  NumMasters*AddrWidth  packed per-master address.
REQ-010 m_wdata_i  in  NumMasters*DataWidth  packed per-master write data.
REQ-011 m_be_i  in  NumMasters*DataWidth/8  packed per-master byte enables.
REQ-012 m_we_i  in  NumMasters  per-master write enable.
REQ-013 m_rsp_valid_o  out  NumMasters  per-master one-cycle response strobe.
REQ-014 m_rsp_rdata_o  out  DataWidth  shared read data, valid with the strobe.
REQ-015 m_rsp_err_o  out  1  shared error flag, valid with the strobe.
REQ-016 s_req_valid_o / s_req_ready_i  out/in  1/1  slave request handshake.
REQ-017 s_addr_o, s_wdata_o, s_be_o, s_we_o  out  AddrWidth, DataWidth, DataWidth/8, 1  slave payload.
REQ-018 s_rsp_valid_i, s_rsp_rdata_i, s_rsp_err_i  in  1, DataWidth, 1  slave response.
REQ-019 grant_idx_o  out  max(1,$clog2(NumMasters))  current owner index.
REQ-020 busy_o  out  1  high when not in IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, REQ and RESP; one transaction outstanding at most.
REQ-022 In IDLE with any m_req_valid_i set: owner <= first valid index searching from ptr upward with wrap; next state REQ.
REQ-023 In REQ: s_req_valid_o=1; payload SHALL be the owner's slice, combinational; m_req_ready_o[owner]=s_req_ready_i; all other ready bits 0.
REQ-024 On s_req_valid_o & s_req_ready_i: next state RESP, timer <= 0; earliest slave acceptance SHALL be the cycle after the IDLE request.
REQ-025 In RESP with s_rsp_valid_i: m_rsp_valid_o[owner]=1 same cycle, rdata/err passed through; next IDLE; ptr <= (owner+1) mod NumMasters.
REQ-026 In RESP without response: timer increments; at timer==TimeoutCycles-1: m_rsp_valid_o[owner]=1, err=1, rdata=0; next IDLE; ptr advances as REQ-025.
REQ-027 s_rsp_valid_i SHALL be ignored outside RESP (late responses dropped).
REQ-028 ptr SHALL change only on completion; an unserved requester SHALL wait at most NumMasters-1 transactions.
REQ-029 m_rsp_valid_o SHALL be one-hot or zero; rdata/err SHALL be 0 when no strobe.
REQ-030 Masters SHALL hold valid and payload stable until ready; a violation is a protocol error flagged by assertion, not handled.
REQ-031 A new request from the completing master SHALL be arbitrable in the cycle after completion.

Reset
REQ-032 rst_n low SHALL force IDLE, ptr=0, owner=0, timer=0.
REQ-033 While and after reset, all *_valid_o, m_req_ready_o and busy_o SHALL be 0, grant_idx_o 0, payload outputs 0.
REQ-034 Reset mid-transaction SHALL abandon it silently; no response strobe SHALL be issued.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum and default parameter constants.
REQ-036 Sub-module rr_grant (combinational: request vector, ptr -> found flag, winner index) SHALL be instantiated once.

Verification
REQ-037 Single master 2 read: slave ready immediate, rsp rdata 0xDEADBEEF 3 cycles later -> m_rsp_valid_o=4'b0100, rdata 0xDEADBEEF, err 0.
REQ-038 All four valid continuously -> grant order 0,1,2,3,0; no master served twice before the others.
REQ-039 Slave silent in RESP, TimeoutCycles=8 -> err strobe on 8th RESP cycle, rdata 0, ptr advanced; response arriving 2 cycles later ignored.
REQ-040 s_req_ready_i low 5 cycles -> s_req_valid_o and payload stable throughout; m_req_ready_o high only in the acceptance cycle.
REQ-041 rst_n low during RESP -> next cycle IDLE, busy_o 0, no m_rsp_valid_o; following request served from master 0 priority.
REQ-042 Master 3 completes while master 3 and master 0 request -> master 0 granted next (wrap-around).
